// File: rtl/divider16_8_seq.sv
// divider16_8_seq: sequential 16/8 unsigned restoring divider with valid/ready handshakes
module divider16_8_seq #(
    parameter logic [15:0] DBZ_QUOTIENT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] quo_q, quo_d;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  dvs_q, dvs_d;
    logic        dbz_q, dbz_d;
    logic [8:0]  part, diff;
    logic        ge;

    // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract
    always_comb begin
        part = {rem_q, quo_q[15]};
        diff = part - {1'b0, dvs_q};
        ge   = part >= {1'b0, dvs_q};
    end

    // Next-state logic; quo_q shifts dividend bits out of the top while quotient bits enter at the bottom
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d   = 5'd0;
                    dvs_d   = divisor;
                    dbz_d   = divisor == 8'd0;
                    quo_d   = divisor == 8'd0 ? DBZ_QUOTIENT : dividend;
                    rem_d   = divisor == 8'd0 ? dividend[7:0] : 8'd0;
                    state_d = divisor == 8'd0 ? DONE : RUN;
                end
            end
            RUN: begin
                rem_d   = ge ? diff[7:0] : part[7:0];
                quo_d   = {quo_q[14:0], ge};
                cnt_d   = cnt_q + 5'd1;
                state_d = cnt_q == 5'd15 ? DONE : RUN;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and working registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            quo_q   <= 16'd0;
            rem_q   <= 8'd0;
            dvs_q   <= 8'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
        end
    end

    // Outputs decode from state; result fields read zero unless a result is being presented
    always_comb begin
        in_ready    = state_q == IDLE;
        out_valid   = state_q == DONE;
        quotient    = out_valid ? quo_q : 16'd0;
        remainder   = out_valid ? rem_q : 8'd0;
        div_by_zero = out_valid ? dbz_q : 1'b0;
    end
endmodule

// File: doc/divider16_8_seq.md
DIVIDER16_8_SEQ -- requirements
Module: divider16_8_seq

Interface
REQ-001 SHALL have parameter DBZ_QUOTIENT, default 16'hFFFF, giving the quotient returned on divide-by-zero.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operands presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port dividend  input  16  unsigned dividend, sampled on accept.
REQ-007 SHALL have port divisor  input  8  unsigned divisor, sampled on accept.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port quotient  output  16  unsigned quotient.
REQ-011 SHALL have port remainder  output  8  unsigned remainder.
REQ-012 SHALL have port div_by_zero  output  1  result came from divisor == 0.

Function
REQ-013 SHALL implement the inverse of the team's 8x8 multipliers: exact unsigned division, with dividend == quotient*divisor + remainder and remainder < divisor whenever divisor != 0.
REQ-014 SHALL use FSM states IDLE, RUN, DONE; IDLE is the only state in which in_ready = 1.
REQ-015 Accept = rising edge with in_valid && in_ready; on accept, SHALL latch operands and clear the iteration counter (5-bit, 0..15).
REQ-016 On accept with divisor != 0, SHALL go IDLE->RUN; with divisor == 0, SHALL go IDLE->DONE directly.
REQ-017 RUN SHALL perform one restoring step per cycle, MSB first: partial remainder (9 bits) = {rem, next dividend bit}; if >= divisor then subtract and set quotient bit to 1, else keep and set it to 0.
REQ-018 RUN SHALL last exactly 16 cycles; the edge completing step 16 SHALL move RUN->DONE and set out_valid, giving out_valid exactly 16 edges after the accepting edge.
REQ-019 Divide-by-zero SHALL give quotient = DBZ_QUOTIENT, remainder = dividend[7:0], div_by_zero = 1, with out_valid 1 edge after accept.
REQ-020 div_by_zero SHALL be 0 for every result with a nonzero divisor.
REQ-021 In DONE, quotient/remainder/div_by_zero/out_valid SHALL hold stable until out_valid && out_ready (backpressure of any length).
REQ-022 On the edge with out_valid && out_ready, SHALL go DONE->IDLE with out_valid = 0; in_ready SHALL rise the next cycle (no same-cycle accept/drain overlap).
REQ-023 in_valid and operand changes outside IDLE SHALL be ignored; operands SHALL be sampled only on accept.
REQ-024 out_ready while out_valid = 0 SHALL have no effect.
REQ-025 quotient/remainder SHALL read 0 whenever out_valid = 0 (no intermediate values exposed).

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, and clear the counter and working registers.
REQ-027 Reset asserted mid-RUN or in DONE SHALL discard the operation with no out_valid pulse; after release, the first accept SHALL behave exactly as from power-up.
REQ-028 Release of rst_n SHALL only take effect at a rising clk edge; no output may glitch high during reset.

Verification
REQ-029 1000/7 -> quotient 142, remainder 6, div_by_zero 0, out_valid exactly 16 edges after accept.
REQ-030 16'hFFFF/8'hFF -> 257, 0; 16'hFFFF/1 -> 16'hFFFF, 0; 3/200 -> 0, 3.
REQ-031 5/0 -> quotient 16'hFFFF, remainder 5, div_by_zero 1, out_valid 1 edge after accept.
REQ-032 Backpressure: 1000/7 with out_ready low 5 cycles -> outputs stable 142/6 throughout, in_ready 0; drain edge -> IDLE, in_ready 1 the next cycle.
REQ-033 Reset pulse at step 8 of 1000/7 -> no out_valid; then 300/9 -> 33, 3 at nominal latency.
REQ-034 Random: 10k operand pairs with random in_valid/out_ready gaps vs. golden model -> zero mismatches, one result per accept, in order.
